imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Serial boot loader and instruction memory sitting directly upstream of the 16-bit MIPS core.
//  Receives a program image as a byte stream and writes it into internal instruction RAM.
//  Holds the core in reset until a valid image has loaded.
//  Then serves instr combinationally from the core's pc.
// PARAMETERS
//  DEPTH   256  instruction words in RAM (power of 2, 2..32768)
//  AW      8    word address width = log2(DEPTH)
//  PC_BYTE 1    1: pc is byte address, word index = pc[AW:1]; 0: word index = pc[AW-1:0]
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   asynchronous, active-high; clears FSM, counters and outputs (not RAM)
//  rx_valid    in   1   rx_data holds a byte
//  rx_data     in   8   received byte
//  rx_ready    out  1   loader can accept a byte; transfer occurs when rx_valid && rx_ready
//  pc          in   16  program counter from core
//  instr       out  16  instruction word to core (combinational read)
//  core_reset  out  1   registered; high holds core in reset
//  load_done   out  1   registered; high while image valid and core running
//  err         out  1   registered; high after length or checksum failure
// BEHAVIOUR
//  Reset values: state=IDLE, core_reset=1, load_done=0, err=0, rx_ready=1, counters/checksum=0.
//  Frame format: 0xA5 sync, LEN_HI, LEN_LO (word count N), N x (hi byte, lo byte), CHK.
//  CHK = XOR of all 2N data bytes.
//  States and transitions (one accepted byte per edge max):
//   IDLE   : byte==0xA5 -> LEN_HI; any other byte is dropped, stay.
//   LEN_HI : latch len[15:8] -> LEN_LO.
//   LEN_LO : latch len[7:0]. len>DEPTH -> ERR; len==0 -> CHK; else waddr=0, chk=0 -> D_HI.
//   D_HI   : hold byte, chk^=byte -> D_LO.
//   D_LO   : write RAM[waddr]={held,byte} on this edge, chk^=byte, waddr++.
//            Exits to CHK when waddr+1==len, else to D_HI.
//   CHK    : byte==chk -> RUN; else -> ERR.
//   RUN    : core_reset=0, load_done=1; bytes accepted and dropped.
//   ERR    : core_reset=1, err=1, rx_ready=0; terminal until reset.
//  core_reset/load_done/err change on the same edge that enters RUN/ERR (1-cycle latency after CHK byte).
//  rx_ready=1 in every state except ERR; no back-pressure otherwise.
//  instr = RAM[idx] when idx<DEPTH, else 16'h0000.
//  idx is the pc slice selected by PC_BYTE; upper pc bits beyond AW must be zero, otherwise 0x0000.
//  instr is valid in every state. Reads during writes return old data for a different address.
//  For the same address, new data appears after the write edge.
//  Words at index>=len keep previous contents. RAM is never cleared by reset.
//  Reset mid-load: FSM to IDLE immediately (async), partial image retained, core_reset=1.
//  len is 16-bit unsigned; waddr is AW+1 bits so len==DEPTH completes without wrap.
// CONFIGURATION
//  IMEM_LOADER_RELOAD_EN defined:
//   - 0xA5 received in RUN or ERR restarts loading: -> LEN_HI.
//   - core_reset=1, load_done=0, err=0 on that edge.
//   - rx_ready=1 in ERR.
//  Undefined: RUN and ERR are terminal until reset. Behaviour is exactly as above.
// TESTING
//  A5 00 02 12 34 AB CD 40 -> RAM[0]=1234, RAM[1]=ABCD.
//   After the CHK edge: core_reset=0, load_done=1. pc=0 -> instr=1234; pc=2 -> ABCD (PC_BYTE=1).
//  A5 00 01 12 34 00 (bad CHK) -> err=1, core_reset=1, rx_ready=0, load_done=0.
//  A5 01 01 (len 257 > DEPTH 256) -> ERR on the LEN_LO edge; no RAM write occurs.
//  A5 00 00 00 -> RUN, with RAM unchanged from its prior contents.
//   Bytes 55 66 before A5 are dropped, with the state staying IDLE.
//  Assert reset after 3 data bytes of a 2-word load -> state IDLE, core_reset=1, RAM[0] retained.
//   A full reload then succeeds.
//  RELOAD_EN: in RUN, send A5 00 01 BE EF 51 -> core_reset pulses high through load, then RAM[0]=BEEF.
//   Without the macro, the same bytes are ignored and load_done stays 1.

Source files
------------

// File: rtl/imem_loader.sv
// Serial boot loader plus instruction RAM for the 16-bit MIPS core: parses an A5-framed image,
// holds the core in reset until the checksum matches. Optional IMEM_LOADER_RELOAD_EN allows re-sync from RUN/ERR.
module imem_loader #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int PC_BYTE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [15:0] pc,
  output logic [15:0] instr,
  output logic        core_reset,
  output logic        load_done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, D_HI, D_LO, CHK, RUN, ERR} state_t;

  localparam logic [7:0] SYNC = 8'hA5;
`ifdef IMEM_LOADER_RELOAD_EN
  localparam logic ERR_READY = 1'b1;
`else
  localparam logic ERR_READY = 1'b0;
`endif

  state_t        state_q;
  logic [15:0]   len_q;
  logic [AW:0]   waddr_q;
  logic [7:0]    chk_q;
  logic [7:0]    hold_q;
  logic          core_reset_q;
  logic          load_done_q;
  logic          err_q;
  logic          rx_ready_q;
  logic [15:0]   mem_q [DEPTH];

  logic          accept;
  logic          wr_en;
  logic [15:0]   len_d;
  logic [AW:0]   waddr_d;
  logic [15:0]   word_pc;

  assign accept  = rx_valid && rx_ready_q;
  assign wr_en   = accept && (state_q == D_LO);
  assign len_d   = {len_q[15:8], rx_data};
  // waddr is one bit wider than the RAM index so a len==DEPTH image terminates without wrapping.
  assign waddr_d = waddr_q + (AW+1)'(1);

  // NOTE: every register here is sequential state, so all updates use non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      waddr_q      <= '0;
      chk_q        <= '0;
      hold_q       <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      err_q        <= 1'b0;
      rx_ready_q   <= 1'b1;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == SYNC) state_q <= LEN_HI;
        end
        LEN_HI: begin
          len_q[15:8] <= rx_data;
          state_q     <= LEN_LO;
        end
        LEN_LO: begin
          len_q[7:0] <= rx_data;
          waddr_q    <= '0;
          chk_q      <= '0;
          if (len_d > 16'(DEPTH)) begin
            state_q    <= ERR;
            err_q      <= 1'b1;
            rx_ready_q <= ERR_READY;
          end else if (len_d == 16'd0) begin
            state_q <= CHK;
          end else begin
            state_q <= D_HI;
          end
        end
        D_HI: begin
          hold_q  <= rx_data;
          chk_q   <= chk_q ^ rx_data;
          state_q <= D_LO;
        end
        D_LO: begin
          chk_q   <= chk_q ^ rx_data;
          waddr_q <= waddr_d;
          state_q <= (16'(waddr_d) == len_q) ? CHK : D_HI;
        end
        CHK: begin
          if (rx_data == chk_q) begin
            state_q      <= RUN;
            core_reset_q <= 1'b0;
            load_done_q  <= 1'b1;
          end else begin
            state_q    <= ERR;
            err_q      <= 1'b1;
            rx_ready_q <= ERR_READY;
          end
        end
        RUN, ERR: begin
`ifdef IMEM_LOADER_RELOAD_EN
          if (rx_data == SYNC) begin
            state_q      <= LEN_HI;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
            rx_ready_q   <= 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the RAM has no reset on purpose; the image must survive a core-side reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr_q[AW-1:0]] <= {hold_q, rx_data};
  end

  // NOTE: both outputs get a default first so this block cannot infer a latch.
  always_comb begin
    word_pc = (PC_BYTE != 0) ? (pc >> 1) : pc;
    instr   = '0;
    if ((word_pc >> AW) == 16'd0) instr = mem_q[word_pc[AW-1:0]];
  end

  assign rx_ready   = rx_ready_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level reference model (word array + expected status flags),
// a pc->instr vector table and hand-written sequences for the length, checksum and reset corner cases.
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

`ifdef IMEM_LOADER_RELOAD_EN
  localparam logic ERR_READY = 1'b1;
`else
  localparam logic ERR_READY = 1'b0;
`endif

  typedef struct {
    logic [15:0] pc;
    logic [15:0] exp_instr;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        core_reset;
  logic        load_done;
  logic        err;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .PC_BYTE(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .pc         (pc),
    .instr      (instr),
    .core_reset (core_reset),
    .load_done  (load_done),
    .err        (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model_mem [DEPTH];
  bit          known     [DEPTH];
  logic        exp_core_reset, exp_load_done, exp_err, exp_ready;
  logic [15:0] frame_words [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic set_exp(input logic cr, input logic ld, input logic er, input logic rdy);
    exp_core_reset = cr;
    exp_load_done  = ld;
    exp_err        = er;
    exp_ready      = rdy;
  endtask

  // Status packed as {core_reset, load_done, err, rx_ready}.
  task automatic check_status(input string name);
    check(name, 16'({core_reset, load_done, err, rx_ready}),
          16'({exp_core_reset, exp_load_done, exp_err, exp_ready}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b1);
    #1 check_status("reset");
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Sends frame_words as a complete image; expected outcome follows from the frame contents alone.
  task automatic run_load(input bit bad_chk);
    logic [15:0] len;
    logic [7:0]  chk;
    len = 16'(frame_words.size());
    chk = 8'h00;
    send_byte(8'hA5);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    foreach (frame_words[i]) begin
      send_byte(frame_words[i][15:8]);
      send_byte(frame_words[i][7:0]);
      chk          = chk ^ frame_words[i][15:8] ^ frame_words[i][7:0];
      model_mem[i] = frame_words[i];
      known[i]     = 1'b1;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
    end
    send_byte(bad_chk ? (chk ^ 8'h5A) : chk);
    if (bad_chk) set_exp(1'b1, 1'b0, 1'b1, ERR_READY);
    else         set_exp(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic read_check(input logic [15:0] p, input string name);
    int widx;
    pc = p;
    #1;
    widx = int'(p >> 1);
    if (widx >= DEPTH)   check(name, instr, 16'h0000);
    else if (known[widx]) check(name, instr, model_mem[widx]);
  endtask

  task automatic rand_reads(input int n, input string name);
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) p = 16'($urandom);
      else                           p = 16'($urandom_range(0, 2 * DEPTH - 1));
      read_check(p, $sformatf("%s_pc%h", name, p));
    end
  endtask

  initial begin
    rd_vec_t     vecs [7];
    logic [15:0] w0, w1;
    logic [7:0]  noise;

    vecs[0] = '{16'h0000, 16'h1234};
    vecs[1] = '{16'h0001, 16'h1234};
    vecs[2] = '{16'h0002, 16'hABCD};
    vecs[3] = '{16'h0003, 16'hABCD};
    vecs[4] = '{16'h0200, 16'h0000};
    vecs[5] = '{16'h0201, 16'h0000};
    vecs[6] = '{16'h8000, 16'h0000};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    pc       = 16'h0000;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    // Leading junk is dropped, then the reference two-word image loads.
    do_reset();
    send_byte(8'h55);
    send_byte(8'h66);
    check_status("idle_drop");
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    check_status("before_chk");
    send_byte(8'h40);
    model_mem[0] = 16'h1234; known[0] = 1'b1;
    model_mem[1] = 16'hABCD; known[1] = 1'b1;
    set_exp(1'b0, 1'b1, 1'b0, 1'b1);
    check_status("spec_run");
    for (int i = 0; i < 7; i++) begin
      pc = vecs[i].pc;
      #1 check($sformatf("vec%0d_pc%h", i, vecs[i].pc), instr, vecs[i].exp_instr);
    end

    // A second frame while running.
`ifdef IMEM_LOADER_RELOAD_EN
    send_byte(8'hA5);
    set_exp(1'b1, 1'b0, 1'b0, 1'b1);
    check_status("reload_sync");
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF);
    check_status("reload_mid");
    send_byte(8'h51);
    model_mem[0] = 16'hBEEF;
    set_exp(1'b0, 1'b1, 1'b0, 1'b1);
    check_status("reload_done");
`else
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h51);
    check_status("run_ignores");
`endif
    read_check(16'h0000, "run_frame_pc0");

    // Image exactly DEPTH words long.
    do_reset();
    frame_words.delete();
    for (int i = 0; i < DEPTH; i++) frame_words.push_back(16'($urandom));
    run_load(1'b0);
    check_status("full_depth");
    read_check(16'h01FE, "last_word");
    read_check(16'h0200, "past_end");
    rand_reads(40, "full");

    // Bad checksum: data is written, loader ends in ERR.
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    model_mem[0] = 16'h1234;
    set_exp(1'b1, 1'b0, 1'b1, ERR_READY);
    check_status("bad_chk");
    read_check(16'h0000, "bad_chk_ram");
`ifdef IMEM_LOADER_RELOAD_EN
    frame_words.delete();
    frame_words.push_back(16'hC0DE);
    run_load(1'b0);
    check_status("reload_from_err");
    read_check(16'h0000, "reload_from_err_pc0");
`endif

    // Length above DEPTH fails on the LEN_LO edge with no RAM write.
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    set_exp(1'b1, 1'b0, 1'b1, ERR_READY);
    check_status("len_gt_depth");
    rand_reads(10, "len_gt");

    // Zero-length image runs with RAM untouched.
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    check_status("len0_wait_chk");
    send_byte(8'h00);
    set_exp(1'b0, 1'b1, 1'b0, 1'b1);
    check_status("len0_run");
    rand_reads(10, "len0");

    // Asynchronous reset part-way through a two-word load.
    do_reset();
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(w0[15:8]); send_byte(w0[7:0]); send_byte(w1[15:8]);
    model_mem[0] = w0;
    @(negedge clk);
    reset = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b1);
    #1 check_status("mid_reset_async");
    read_check(16'h0000, "mid_reset_ram0");
    read_check(16'h0002, "mid_reset_ram1");
    @(negedge clk);
    reset = 1'b0;
    frame_words.delete();
    frame_words.push_back(16'($urandom));
    frame_words.push_back(16'($urandom));
    run_load(1'b0);
    check_status("after_mid_reset");
    read_check(16'h0000, "after_mid_pc0");
    read_check(16'h0002, "after_mid_pc2");

    // Random frames with noise, gaps and occasional bad checksums.
    for (int it = 0; it < 12; it++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) begin
        noise = 8'($urandom);
        if (noise == 8'hA5) noise = 8'h00;
        send_byte(noise);
      end
      frame_words.delete();
      repeat ($urandom_range(1, 20)) frame_words.push_back(16'($urandom));
      run_load($urandom_range(0, 3) == 0);
      check_status($sformatf("rand%0d_status", it));
      rand_reads(6, $sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
